// File: rtl/rf_op_sequencer_pkg.sv
// Shared types for the register-file operation sequencer: opcodes and FSM states.
package rf_seq_pkg;
  typedef enum logic [2:0] {
    OP_LOADI = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_AND   = 3'b011,
    OP_OR    = 3'b100,
    OP_XOR   = 3'b101,
    OP_MOV   = 3'b110,
    OP_ILL   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_e;
endpackage

// File: rtl/rf_op_sequencer_if.sv
// Command handshake between an issuer (master) and the sequencer (slave).
interface rf_op_sequencer_if #(parameter int N = 4, parameter int W = 8);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [N-1:0] cmd_rd;
  logic [N-1:0] cmd_rs1;
  logic [N-1:0] cmd_rs2;
  logic [W-1:0] cmd_imm;

  modport master (output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
                  input  cmd_ready);
  modport slave  (input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
                  output cmd_ready);
endinterface

// File: rtl/rf_op_sequencer_alu.sv
// Combinational ALU; evaluates in W+1 bits so ADD carry and SUB borrow fall out of the top bit.
module rf_alu
  import rf_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] imm,
  output logic [W-1:0] res,
  output logic         carry,
  output logic         illegal
);
  logic [W:0] wide;

  always_comb begin
    wide    = '0;
    illegal = 1'b0;
    case (op)
      OP_LOADI: wide = {1'b0, imm};
      OP_ADD:   wide = {1'b0, a} + {1'b0, b};
      OP_SUB:   wide = {1'b0, a} - {1'b0, b};
      OP_AND:   wide = {1'b0, a & b};
      OP_OR:    wide = {1'b0, a | b};
      OP_XOR:   wide = {1'b0, a ^ b};
      OP_MOV:   wide = {1'b0, a};
      default:  illegal = 1'b1;
    endcase
  end

  assign res   = wide[W-1:0];
  // bit W of the subtraction is set exactly when a < b (unsigned borrow)
  assign carry = ((op == OP_ADD) || (op == OP_SUB)) && wide[W];
endmodule

// File: rtl/rf_op_sequencer.sv
// Four-state IDLE/READ/EXEC/WRITE sequencer driving a 2R1W register file.
module rf_op_sequencer
  import rf_seq_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  rf_op_sequencer_if.slave    cif,
  output logic                rf_we,
  output logic [N-1:0]        rf_addr_rd,
  output logic [N-1:0]        rf_addr_rs1,
  output logic [N-1:0]        rf_addr_rs2,
  output logic [W-1:0]        rf_data_in,
  input  logic [W-1:0]        rf_rs1,
  input  logic [W-1:0]        rf_rs2,
  output logic [W-1:0]        result,
  output logic                flag_zero,
  output logic                flag_carry,
  output logic                done,
  output logic                err
);
  typedef struct packed {
    op_e          op;
    logic [W-1:0] imm;
  } cmd_t;

  state_e       state;
  cmd_t         cmd;
  logic [W-1:0] opa, opb;
  logic [W-1:0] alu_res;
  logic         alu_carry, alu_ill;

  assign cif.cmd_ready = (state == S_IDLE);

  rf_alu #(.W(W)) u_alu (
    .op      (cmd.op),
    .a       (opa),
    .b       (opb),
    .imm     (cmd.imm),
    .res     (alu_res),
    .carry   (alu_carry),
    .illegal (alu_ill)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cmd         <= '0;
      opa         <= '0;
      opb         <= '0;
      result      <= '0;
      flag_zero   <= 1'b0;
      flag_carry  <= 1'b0;
      rf_addr_rd  <= '0;
      rf_addr_rs1 <= '0;
      rf_addr_rs2 <= '0;
      rf_data_in  <= '0;
      rf_we       <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: if (cif.cmd_valid) begin
          cmd.op      <= op_e'(cif.cmd_op);
          cmd.imm     <= cif.cmd_imm;
          rf_addr_rd  <= cif.cmd_rd;
          rf_addr_rs1 <= cif.cmd_rs1;
          rf_addr_rs2 <= cif.cmd_rs2;
          state       <= S_READ;
        end
        S_READ: begin
          opa   <= rf_rs1;
          opb   <= rf_rs2;
          state <= S_EXEC;
        end
        S_EXEC: begin
          // write data tracks result, so an illegal op leaves both untouched
          if (!alu_ill) begin
            result     <= alu_res;
            rf_data_in <= alu_res;
            flag_zero  <= (alu_res == '0);
            flag_carry <= alu_carry;
          end
          rf_we <= !alu_ill;
          done  <= 1'b1;
          err   <= alu_ill;
          state <= S_WRITE;
        end
        S_WRITE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_op_sequencer.sv
// Randomized bench for rf_op_sequencer with a behavioural register file and arithmetic reference model.
module tb_rf_op_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       rf_we;
  logic [3:0] rf_addr_rd, rf_addr_rs1, rf_addr_rs2;
  logic [7:0] rf_data_in, rf_rs1, rf_rs2, result;
  logic       flag_zero, flag_carry, done, err;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] rf_mem [16] = '{default: 8'h00};
  logic [7:0] mdl    [16] = '{default: 8'h00};
  logic [7:0] mdl_res = 8'h00;
  logic       mdl_z = 1'b0, mdl_c = 1'b0;

  rf_op_sequencer_if #(.N(4), .W(8)) cif ();

  rf_op_sequencer #(.N(4), .W(8)) dut (
    .clk(clk), .rst(rst), .cif(cif),
    .rf_we(rf_we), .rf_addr_rd(rf_addr_rd), .rf_addr_rs1(rf_addr_rs1),
    .rf_addr_rs2(rf_addr_rs2), .rf_data_in(rf_data_in),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .result(result),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // register file: r0 reads as zero and discards writes
  assign rf_rs1 = (rf_addr_rs1 == 4'd0) ? 8'h00 : rf_mem[rf_addr_rs1];
  assign rf_rs2 = (rf_addr_rs2 == 4'd0) ? 8'h00 : rf_mem[rf_addr_rs2];
  always @(posedge clk) if (rf_we && rf_addr_rd != 4'd0) rf_mem[rf_addr_rd] <= rf_data_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge of the following IDLE cycle.
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic [7:0] imm, input bit hold);
    int waitc, a, b, s;
    logic [7:0] r, old_res;
    logic c, ill;
    cif.cmd_op = op; cif.cmd_rd = rd; cif.cmd_rs1 = rs1; cif.cmd_rs2 = rs2;
    cif.cmd_imm = imm; cif.cmd_valid = 1'b1;
    waitc = 0;
    while (!cif.cmd_ready && waitc < 8) begin @(negedge clk); waitc++; end
    chk("ready_wait", waitc, 0);
    if (waitc >= 8) begin cif.cmd_valid = 1'b0; return; end

    a = int'(mdl[rs1]); b = int'(mdl[rs2]);
    r = mdl_res; c = 1'b0; ill = 1'b0;
    case (op)
      3'd0: r = imm;
      3'd1: begin s = a + b; r = 8'(s % 256); c = (s > 255); end
      3'd2: begin s = a - b + 256; r = 8'(s % 256); c = (a < b); end
      3'd3: r = 8'(a & b);
      3'd4: r = 8'(a | b);
      3'd5: r = 8'(a ^ b);
      3'd6: r = 8'(a);
      default: ill = 1'b1;
    endcase
    old_res = mdl_res;

    @(negedge clk);
    if (!hold) cif.cmd_valid = 1'b0;
    chk("read_ready", cif.cmd_ready, 0);
    chk("read_we", rf_we, 0);
    chk("read_done", done, 0);
    chk("read_rs1", rf_addr_rs1, rs1);
    chk("read_rs2", rf_addr_rs2, rs2);

    @(negedge clk);
    chk("exec_ready", cif.cmd_ready, 0);
    chk("exec_we", rf_we, 0);
    chk("exec_done", done, 0);
    chk("exec_res", result, old_res);

    if (!ill) begin mdl_res = r; mdl_z = (r == 8'h00); mdl_c = c; end
    @(negedge clk);
    chk("wr_ready", cif.cmd_ready, 0);
    chk("wr_done", done, 1);
    chk("wr_err", err, ill);
    chk("wr_we", rf_we, !ill);
    if (!ill) chk("wr_addr", rf_addr_rd, rd);
    chk("wr_data", rf_data_in, mdl_res);
    chk("wr_res", result, mdl_res);
    chk("wr_zero", flag_zero, mdl_z);
    chk("wr_carry", flag_carry, mdl_c);
    if (!ill && rd != 4'd0) mdl[rd] = r;

    @(negedge clk);
    chk("idle_ready", cif.cmd_ready, 1);
    chk("idle_we", rf_we, 0);
    chk("idle_done", done, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cif.cmd_valid = 1'b0; cif.cmd_op = '0; cif.cmd_rd = '0; cif.cmd_rs1 = '0;
    cif.cmd_rs2 = '0; cif.cmd_imm = '0;
    rst = 1'b1;
    cif.cmd_valid = 1'b1; // ignored while in reset
    repeat (2) @(negedge clk);
    chk("rst_we", rf_we, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_res", result, 0);
    chk("rst_data", rf_data_in, 0);
    chk("rst_addr", {rf_addr_rd, rf_addr_rs1, rf_addr_rs2}, 0);
    chk("rst_flags", {flag_zero, flag_carry}, 0);
    chk("rst_ready", cif.cmd_ready, 1);
    cif.cmd_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    do_cmd(3'd0, 4'd3, 4'd0, 4'd0, 8'h5A, 1'b0);
    do_cmd(3'd0, 4'd1, 4'd0, 4'd0, 8'hF0, 1'b0);
    do_cmd(3'd0, 4'd2, 4'd0, 4'd0, 8'h20, 1'b0);
    do_cmd(3'd1, 4'd4, 4'd1, 4'd2, 8'h00, 1'b0);
    chk("add_ovf", {result, flag_carry}, {8'h10, 1'b1});
    do_cmd(3'd2, 4'd5, 4'd2, 4'd1, 8'h00, 1'b0);
    chk("sub_borrow", {result, flag_carry, flag_zero}, {8'h30, 1'b1, 1'b0});
    do_cmd(3'd2, 4'd6, 4'd1, 4'd1, 8'h00, 1'b0);
    chk("sub_zero", {result, flag_zero, flag_carry}, {8'h00, 1'b1, 1'b0});
    do_cmd(3'd5, 4'd8, 4'd1, 4'd1, 8'h00, 1'b0);
    chk("xor_zero", {result, flag_zero}, {8'h00, 1'b1});
    do_cmd(3'd1, 4'd4, 4'd1, 4'd2, 8'h00, 1'b1);
    do_cmd(3'd6, 4'd7, 4'd4, 4'd0, 8'h00, 1'b1);
    cif.cmd_valid = 1'b0;
    chk("mov_dep", rf_mem[7], 8'h10);
    do_cmd(3'd7, 4'd9, 4'd1, 4'd2, 8'hAA, 1'b0);
    chk("ill_hold", result, 8'h10);
    do_cmd(3'd0, 4'd0, 4'd0, 4'd0, 8'h77, 1'b0);
    do_cmd(3'd6, 4'd10, 4'd0, 4'd0, 8'h00, 1'b0);
    chk("r0_zero", rf_mem[10], 8'h00);

    // reset during EXEC of ADD r2 = r1 + r3
    cif.cmd_op = 3'd1; cif.cmd_rd = 4'd2; cif.cmd_rs1 = 4'd1; cif.cmd_rs2 = 4'd3;
    cif.cmd_valid = 1'b1;
    @(negedge clk); cif.cmd_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("mrst_we", rf_we, 0);
    chk("mrst_done", done, 0);
    chk("mrst_res", result, 0);
    mdl_res = 8'h00; mdl_z = 1'b0; mdl_c = 1'b0;
    @(negedge clk);
    chk("mrst_ready", cif.cmd_ready, 1);
    chk("mrst_we2", rf_we, 0);
    chk("mrst_done2", done, 0);
    chk("mrst_r2", rf_mem[2], mdl[2]);

    for (int i = 0; i < 200; i++) begin
      do_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    cif.cmd_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) chk($sformatf("reg%0d", i), rf_mem[i], mdl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
